// File: rtl/ray_box_march.sv
// ray_box_march: ray marcher against an origin-centred axis-aligned box.
// One signed-distance sample is taken per clock in MARCH. SHADE turns the hit
// face into a clamped Lambert intensity and pulses done_o.
// Optional feature: define RAY_BOX_OVERSTEP_EN to advance the ray by 1.25x
// each step (over-relaxation). total_dist still accumulates the plain sdf.
module ray_box_march #(
    parameter int                 WIDTH     = 16,
    parameter int                 FRAC      = 8,
    parameter int                 MAX_STEPS = 32,
    parameter logic [WIDTH-1:0]   HIT_EPS   = 16'h0008,
    parameter logic [WIDTH-1:0]   MAX_DIST  = 16'h0800,
    localparam int                SW        = $clog2(MAX_STEPS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] origin_x_i,
    input  logic [WIDTH-1:0] origin_y_i,
    input  logic [WIDTH-1:0] origin_z_i,
    input  logic [WIDTH-1:0] dir_x_i,
    input  logic [WIDTH-1:0] dir_y_i,
    input  logic [WIDTH-1:0] dir_z_i,
    input  logic [WIDTH-1:0] half_x_i,
    input  logic [WIDTH-1:0] half_y_i,
    input  logic [WIDTH-1:0] half_z_i,
    input  logic [WIDTH-1:0] light_x_i,
    input  logic [WIDTH-1:0] light_y_i,
    input  logic [WIDTH-1:0] light_z_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             hit_o,
    output logic [WIDTH-1:0] intensity_o,
    output logic [SW-1:0]    steps_o
);

    typedef enum logic [1:0] {S_IDLE, S_MARCH, S_SHADE} state_t;

    localparam logic signed [WIDTH-1:0] S_MIN      = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] S_MAX      = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] EPS_S      = HIT_EPS;
    localparam logic signed [WIDTH:0]   MAX_DIST_X = {1'b0, MAX_DIST};

    // Per-axis views of the input pins (index 0=x, 1=y, 2=z)
    logic signed [WIDTH-1:0] org_v   [3];
    logic signed [WIDTH-1:0] dir_v   [3];
    logic signed [WIDTH-1:0] half_v  [3];
    logic signed [WIDTH-1:0] light_v [3];

    assign org_v[0]   = origin_x_i;
    assign org_v[1]   = origin_y_i;
    assign org_v[2]   = origin_z_i;
    assign dir_v[0]   = dir_x_i;
    assign dir_v[1]   = dir_y_i;
    assign dir_v[2]   = dir_z_i;
    assign half_v[0]  = half_x_i;
    assign half_v[1]  = half_y_i;
    assign half_v[2]  = half_z_i;
    assign light_v[0] = light_x_i;
    assign light_v[1] = light_y_i;
    assign light_v[2] = light_z_i;

    // State and latched ray parameters
    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] p_q     [3];
    logic signed [WIDTH-1:0] p_d     [3];
    logic signed [WIDTH-1:0] dir_q   [3];
    logic signed [WIDTH-1:0] dir_d   [3];
    logic signed [WIDTH-1:0] half_q  [3];
    logic signed [WIDTH-1:0] half_d  [3];
    logic signed [WIDTH-1:0] light_q [3];
    logic signed [WIDTH-1:0] light_d [3];
    logic signed [WIDTH-1:0] dist_q, dist_d;
    logic [SW-1:0]           cnt_q, cnt_d;
    logic [1:0]              face_q, face_d;
    logic                    mhit_q, mhit_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    hit_q, hit_d;
    logic [WIDTH-1:0]        int_q, int_d;
    logic [SW-1:0]           steps_q, steps_d;

    // Per-axis sample datapath
    logic signed [WIDTH-1:0]   abs_v  [3];
    logic signed [WIDTH-1:0]   a_v    [3];
    logic signed [2*WIDTH-1:0] prod_v [3];
    logic signed [WIDTH-1:0]   step_v [3];
    logic signed [WIDTH-1:0]   adv_v  [3];
    logic signed [WIDTH-1:0]   sdf;
    logic [1:0]                face_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_axis
            // |p| saturates so the most negative coordinate does not wrap
            assign abs_v[gi]  = (p_q[gi] == S_MIN) ? S_MAX :
                                (p_q[gi][WIDTH-1] ? -p_q[gi] : p_q[gi]);
            assign a_v[gi]    = abs_v[gi] - half_q[gi];
            // Full-precision signed product, arithmetic shift, truncate
            assign prod_v[gi] = $signed({{WIDTH{dir_q[gi][WIDTH-1]}}, dir_q[gi]})
                              * $signed({{WIDTH{sdf[WIDTH-1]}}, sdf});
            assign step_v[gi] = WIDTH'(prod_v[gi] >>> FRAC);
`ifdef RAY_BOX_OVERSTEP_EN
            assign adv_v[gi]  = step_v[gi] + (step_v[gi] >>> 2);
`else
            assign adv_v[gi]  = step_v[gi];
`endif
        end
    endgenerate

    // Box sdf is the largest per-axis distance; ties resolve x > y > z
    always_comb begin
        face_sel = 2'd0;
        sdf      = a_v[0];
        if (a_v[0] >= a_v[1] && a_v[0] >= a_v[2]) begin
            face_sel = 2'd0;
            sdf      = a_v[0];
        end else if (a_v[1] >= a_v[2]) begin
            face_sel = 2'd1;
            sdf      = a_v[1];
        end else begin
            face_sel = 2'd2;
            sdf      = a_v[2];
        end
    end

    logic signed [WIDTH:0] dist_sum;
    logic [SW-1:0]         cnt_inc;
    assign dist_sum = {dist_q[WIDTH-1], dist_q} + {sdf[WIDTH-1], sdf};
    assign cnt_inc  = cnt_q + SW'(1);

    // Shading: the normal is +-1 on the face axis, so n.L is +-light_face
    logic signed [WIDTH-1:0] light_sel, p_sel, ndotl;
    logic [WIDTH-1:0]        shade_val;
    always_comb begin
        light_sel = light_q[0];
        p_sel     = p_q[0];
        case (face_q)
            2'd1:    begin light_sel = light_q[1]; p_sel = p_q[1]; end
            2'd2:    begin light_sel = light_q[2]; p_sel = p_q[2]; end
            default: begin light_sel = light_q[0]; p_sel = p_q[0]; end
        endcase
        if (p_sel[WIDTH-1])
            ndotl = (light_sel == S_MIN) ? S_MAX : -light_sel;
        else
            ndotl = light_sel;
        shade_val = ndotl[WIDTH-1] ? '0 : ndotl;
    end

    // Next-state and output logic for IDLE -> MARCH -> SHADE
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        dir_d   = dir_q;
        half_d  = half_q;
        light_d = light_q;
        dist_d  = dist_q;
        cnt_d   = cnt_q;
        face_d  = face_q;
        mhit_d  = mhit_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hit_d   = hit_q;
        int_d   = int_q;
        steps_d = steps_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    p_d     = org_v;
                    dir_d   = dir_v;
                    half_d  = half_v;
                    light_d = light_v;
                    dist_d  = '0;
                    cnt_d   = '0;
                    face_d  = 2'd0;
                    mhit_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_MARCH;
                end
            end
            S_MARCH: begin
                cnt_d = cnt_inc;
                if (sdf <= EPS_S) begin
                    mhit_d  = 1'b1;
                    face_d  = face_sel;
                    state_d = S_SHADE;
                end else if (dist_sum >= MAX_DIST_X || cnt_inc == SW'(MAX_STEPS)) begin
                    mhit_d  = 1'b0;
                    state_d = S_SHADE;
                end else begin
                    for (int i = 0; i < 3; i++) p_d[i] = p_q[i] + adv_v[i];
                    dist_d = dist_q + sdf;
                end
            end
            S_SHADE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                hit_d   = mhit_q;
                int_d   = mhit_q ? shade_val : '0;
                steps_d = cnt_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            for (int i = 0; i < 3; i++) begin
                p_q[i]     <= '0;
                dir_q[i]   <= '0;
                half_q[i]  <= '0;
                light_q[i] <= '0;
            end
            dist_q  <= '0;
            cnt_q   <= '0;
            face_q  <= 2'd0;
            mhit_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hit_q   <= 1'b0;
            int_q   <= '0;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            dir_q   <= dir_d;
            half_q  <= half_d;
            light_q <= light_d;
            dist_q  <= dist_d;
            cnt_q   <= cnt_d;
            face_q  <= face_d;
            mhit_q  <= mhit_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hit_q   <= hit_d;
            int_q   <= int_d;
            steps_q <= steps_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign hit_o       = hit_q;
    assign intensity_o = int_q;
    assign steps_o     = steps_q;

endmodule
